// File: rtl/axi_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and constants for the AXI write-channel arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ADDR, DATA, RESP)
//   BURST_*     : AXI AxBURST encodings
//   RESP_*      : AXI xRESP encodings
// ---------------------------------------------------------------------------
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first set request bit found
// searching upward from ptr_i+1 (mod NREQ).
//   req_i   in  NREQ  request vector
//   ptr_i   in  IW    index of the last winner
//   en_i    in  1     enable; all outputs 0 when low
//   grant_o out NREQ  one-hot winner
//   idx_o   out IW    encoded winner
//   any_o   out 1     a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        if (en_i) begin
            // i runs 1..NREQ so the previous winner is examined last
            for (int unsigned i = 1; i <= NREQ; i++) begin
                cand = IW'((32'(ptr_i) + i) % NREQ);
                if (!found && req_i[cand]) begin
                    found         = 1'b1;
                    grant_o[cand] = 1'b1;
                    idx_o         = cand;
                end
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter
// Shares one AXI write master channel (AW/W/B) among NREQ requesters.
// One burst at a time, round-robin, grant held until the B handshake.
// Ports:
//   clk, rst                          clock, async active-high reset
//   req_aw*  (valid/ready/addr/len/size/burst)   per-requester AW, packed
//   req_w*   (data/strb/valid/ready)             per-requester W, packed
//   req_b*   (resp/valid/ready)                  per-requester B, packed
//   axi_aw*  registered AW beat to the shared port
//   axi_w*   W muxed from the granted requester, wlast from a beat counter
//   axi_b*   B routed back to the granted requester
//   grant    one-hot owner (0 in IDLE), busy = not IDLE
// ---------------------------------------------------------------------------
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_awvalid,
    output logic [NREQ-1:0]        req_awready,
    input  logic [NREQ*AW-1:0]     req_awaddr,
    input  logic [NREQ*8-1:0]      req_awlen,
    input  logic [NREQ*3-1:0]      req_awsize,
    input  logic [NREQ*2-1:0]      req_awburst,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*DW/8-1:0]   req_wstrb,
    input  logic [NREQ-1:0]        req_wvalid,
    output logic [NREQ-1:0]        req_wready,
    output logic [NREQ*2-1:0]      req_bresp,
    output logic [NREQ-1:0]        req_bvalid,
    input  logic [NREQ-1:0]        req_bready,
    output logic [AW-1:0]          axi_awaddr,
    output logic [7:0]             axi_awlen,
    output logic [2:0]             axi_awsize,
    output logic [1:0]             axi_awburst,
    output logic                   axi_awvalid,
    input  logic                   axi_awready,
    output logic [DW-1:0]          axi_wdata,
    output logic [DW/8-1:0]        axi_wstrb,
    output logic                   axi_wlast,
    output logic                   axi_wvalid,
    input  logic                   axi_wready,
    input  logic [1:0]             axi_bresp,
    input  logic                   axi_bvalid,
    output logic                   axi_bready,
    output logic [NREQ-1:0]        grant,
    output logic                   busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned SW = DW / 8;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [7:0]    awlen_q, awlen_d;
    logic [2:0]    awsize_q, awsize_d;
    logic [1:0]    awburst_q, awburst_d;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            w_hs;
    logic            b_hs;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i   (req_awvalid),
        .ptr_i   (rr_ptr_q),
        .en_i    (state_q == IDLE),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign axi_awaddr  = awaddr_q;
    assign axi_awlen   = awlen_q;
    assign axi_awsize  = awsize_q;
    assign axi_awburst = awburst_q;
    // awvalid is a decode of the state register, so it is registered
    assign axi_awvalid = (state_q == ADDR);
    assign busy        = (state_q != IDLE);

    // Datapath muxing; every routed signal is forced to 0 outside its phase
    always_comb begin
        req_awready = '0;
        req_wready  = '0;
        req_bvalid  = '0;
        req_bresp   = '0;
        grant       = '0;
        axi_wvalid  = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wlast   = 1'b0;
        axi_bready  = 1'b0;
        unique case (state_q)
            IDLE: req_awready = arb_grant;
            DATA: begin
                axi_wvalid     = req_wvalid[g_q];
                axi_wdata      = req_wdata[g_q*DW +: DW];
                axi_wstrb      = req_wstrb[g_q*SW +: SW];
                axi_wlast      = (beat_cnt_q == 8'd0);
                req_wready[g_q] = axi_wready;
            end
            RESP: begin
                req_bvalid[g_q]        = axi_bvalid;
                req_bresp[g_q*2 +: 2]  = axi_bresp;
                axi_bready             = req_bready[g_q];
            end
            default: ;
        endcase
        if (state_q != IDLE) begin
            grant[g_q] = 1'b1;
        end
    end

    assign w_hs = axi_wvalid & axi_wready;
    assign b_hs = axi_bvalid & axi_bready;

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awsize_d   = awsize_q;
        awburst_d  = awburst_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    g_d       = arb_idx;
                    awaddr_d  = req_awaddr[arb_idx*AW +: AW];
                    awlen_d   = req_awlen[arb_idx*8 +: 8];
                    awsize_d  = req_awsize[arb_idx*3 +: 3];
                    awburst_d = req_awburst[arb_idx*2 +: 2];
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (axi_awready) begin
                    beat_cnt_d = awlen_q;
                    state_d    = DATA;
                end
            end
            DATA: begin
                // beat_cnt counts remaining beats after the current one
                if (w_hs) begin
                    if (beat_cnt_q == 8'd0) begin
                        state_d = RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    rr_ptr_d = g_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            g_q        <= '0;
            rr_ptr_q   <= IW'(NREQ - 1);
            beat_cnt_q <= '0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            awsize_q   <= '0;
            awburst_q  <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            awsize_q   <= awsize_d;
            awburst_q  <= awburst_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 64;
    localparam int unsigned SW   = DW / 8;

    logic                 clk, rst;
    logic [NREQ-1:0]      req_awvalid, req_awready;
    logic [NREQ*AW-1:0]   req_awaddr;
    logic [NREQ*8-1:0]    req_awlen;
    logic [NREQ*3-1:0]    req_awsize;
    logic [NREQ*2-1:0]    req_awburst;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SW-1:0]   req_wstrb;
    logic [NREQ-1:0]      req_wvalid, req_wready;
    logic [NREQ*2-1:0]    req_bresp;
    logic [NREQ-1:0]      req_bvalid, req_bready;
    logic [AW-1:0]        axi_awaddr;
    logic [7:0]           axi_awlen;
    logic [2:0]           axi_awsize;
    logic [1:0]           axi_awburst;
    logic                 axi_awvalid, axi_awready;
    logic [DW-1:0]        axi_wdata;
    logic [SW-1:0]        axi_wstrb;
    logic                 axi_wlast, axi_wvalid, axi_wready;
    logic [1:0]           axi_bresp;
    logic                 axi_bvalid, axi_bready;
    logic [NREQ-1:0]      grant;
    logic                 busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    axi_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_awvalid(req_awvalid), .req_awready(req_awready),
        .req_awaddr(req_awaddr), .req_awlen(req_awlen),
        .req_awsize(req_awsize), .req_awburst(req_awburst),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_wvalid(req_wvalid), .req_wready(req_wready),
        .req_bresp(req_bresp), .req_bvalid(req_bvalid), .req_bready(req_bready),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task clear_inputs();
        req_awvalid = '0; req_awaddr = '0; req_awlen = '0; req_awsize = '0;
        req_awburst = '0; req_wdata = '0; req_wstrb = '0; req_wvalid = '0;
        req_bready = '0; axi_awready = 1'b0; axi_wready = 1'b0;
        axi_bresp = '0; axi_bvalid = 1'b0;
    endtask

    task test_reset();
        #1;
        total_cnt++;
        if ({busy, grant, axi_awvalid, axi_wvalid, axi_bready, req_awready} !== 7'd0)
            $display("FAIL reset_ctrl got=%b exp=0", {busy, grant, axi_awvalid, axi_wvalid, axi_bready, req_awready});
        else pass_cnt++;
        total_cnt++;
        if ({axi_awaddr, axi_awlen, axi_wlast, req_wready, req_bvalid} !== '0)
            $display("FAIL reset_data got=%h exp=0", {axi_awaddr, axi_awlen, axi_wlast, req_wready, req_bvalid});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task test_single();
        clear_inputs();
        @(negedge clk);
        req_awvalid = 2'b01; req_awaddr[31:0] = 32'h0000_1000; req_awlen[7:0] = 8'd3;
        req_awsize[2:0] = 3'd3; req_awburst[1:0] = BURST_INCR;
        axi_awready = 1'b1; axi_wready = 1'b1;
        #1;
        total_cnt++;
        if ({req_awready, axi_awvalid, busy} !== 4'b0100)
            $display("FAIL single_grant got=%b exp=0100", {req_awready, axi_awvalid, busy});
        else pass_cnt++;
        @(negedge clk);
        req_awvalid = 2'b00;
        #1;
        total_cnt++;
        if ({axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst} !== {1'b1, 32'h0000_1000, 8'd3, 3'd3, BURST_INCR})
            $display("FAIL single_aw got=%h exp=%h", {axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst},
                     {1'b1, 32'h0000_1000, 8'd3, 3'd3, BURST_INCR});
        else pass_cnt++;
        total_cnt++;
        if ({grant, busy, req_awready} !== 5'b01100)
            $display("FAIL single_owner got=%b exp=01100", {grant, busy, req_awready});
        else pass_cnt++;
        @(negedge clk);
        req_wvalid = 2'b01; req_wstrb[7:0] = 8'hFF;
        for (int b = 0; b < 4; b++) begin
            req_wdata[63:0] = 64'hA5A5_0000_0000_0000 | 64'(b);
            #1;
            total_cnt++;
            if ({axi_wvalid, req_wready, axi_wlast, axi_wdata} !== {1'b1, 2'b01, (b == 3), 64'hA5A5_0000_0000_0000 | 64'(b)})
                $display("FAIL single_beat%0d got=%h exp=%h", b, {axi_wvalid, req_wready, axi_wlast, axi_wdata},
                         {1'b1, 2'b01, (b == 3), 64'hA5A5_0000_0000_0000 | 64'(b)});
            else pass_cnt++;
            @(negedge clk);
        end
        req_wvalid = 2'b00; axi_bvalid = 1'b1; axi_bresp = RESP_OKAY; req_bready = 2'b01;
        #1;
        total_cnt++;
        if ({req_bvalid, req_bresp, axi_bready, busy, axi_wvalid} !== 9'b01_0000_1_1_0)
            $display("FAIL single_resp got=%b exp=010000110", {req_bvalid, req_bresp, axi_bready, busy, axi_wvalid});
        else pass_cnt++;
        @(negedge clk);
        axi_bvalid = 1'b0;
        #1;
        total_cnt++;
        if ({busy, grant} !== 3'b000)
            $display("FAIL single_idle got=%b exp=000", {busy, grant});
        else pass_cnt++;
    endtask

    task test_two_req();
        logic [1:0]  exp_g;
        logic [31:0] exp_a;
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_awvalid = 2'b11; req_awaddr = {32'h0000_0200, 32'h0000_0100};
        req_wvalid = 2'b11; req_wstrb = '1;
        axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1; req_bready = 2'b11;
        for (int r = 0; r < 4; r++) begin
            exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (r % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            #1;
            total_cnt++;
            if ({req_awready, busy} !== {exp_g, 1'b0})
                $display("FAIL rr_pick%0d got=%b exp=%b", r, {req_awready, busy}, {exp_g, 1'b0});
            else pass_cnt++;
            @(negedge clk); #1;
            total_cnt++;
            if ({grant, axi_awaddr} !== {exp_g, exp_a})
                $display("FAIL rr_addr%0d got=%h exp=%h", r, {grant, axi_awaddr}, {exp_g, exp_a});
            else pass_cnt++;
            @(negedge clk); #1;
            total_cnt++;
            if ({req_wready, axi_wlast} !== {exp_g, 1'b1})
                $display("FAIL rr_data%0d got=%b exp=%b", r, {req_wready, axi_wlast}, {exp_g, 1'b1});
            else pass_cnt++;
            @(negedge clk); #1;
            total_cnt++;
            if (req_bvalid !== exp_g)
                $display("FAIL rr_resp%0d got=%b exp=%b", r, req_bvalid, exp_g);
            else pass_cnt++;
            if (r == 3) req_awvalid = 2'b00;
            @(negedge clk);
        end
    endtask

    task test_awlen0_early_w();
        clear_inputs();
        @(negedge clk);
        req_awvalid = 2'b01; req_awaddr[31:0] = 32'h0000_3000; req_awlen[7:0] = 8'd0;
        req_wvalid = 2'b01; req_wdata[63:0] = 64'hCAFE; req_wstrb[7:0] = 8'h0F;
        axi_wready = 1'b1;
        #1;
        total_cnt++;
        if ({req_awready, req_wready, axi_wvalid} !== 5'b01000)
            $display("FAIL early_w_idle got=%b exp=01000", {req_awready, req_wready, axi_wvalid});
        else pass_cnt++;
        @(negedge clk);
        req_awvalid = 2'b00;
        #1;
        total_cnt++;
        if ({req_wready, axi_wvalid, axi_awvalid} !== 4'b0001)
            $display("FAIL early_w_addr got=%b exp=0001", {req_wready, axi_wvalid, axi_awvalid});
        else pass_cnt++;
        axi_awready = 1'b1;
        @(negedge clk);
        axi_awready = 1'b0;
        #1;
        total_cnt++;
        if ({axi_wvalid, axi_wlast, req_wready, axi_wstrb} !== {1'b1, 1'b1, 2'b01, 8'h0F})
            $display("FAIL len0_beat got=%b exp=%b", {axi_wvalid, axi_wlast, req_wready, axi_wstrb},
                     {1'b1, 1'b1, 2'b01, 8'h0F});
        else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++;
        if ({axi_wvalid, req_wready, busy} !== 4'b0001)
            $display("FAIL len0_after got=%b exp=0001", {axi_wvalid, req_wready, busy});
        else pass_cnt++;
        axi_bvalid = 1'b1; req_bready = 2'b01;
        @(negedge clk);
        axi_bvalid = 1'b0; req_wvalid = 2'b00;
        #1;
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL len0_done got=%b exp=0", busy);
        else pass_cnt++;
    endtask

    task test_stall();
        logic [4:0] exp_last;
        exp_last = 5'b11000;
        clear_inputs();
        @(negedge clk);
        req_awvalid = 2'b10; req_awaddr[63:32] = 32'hDEAD_0000; req_awlen[15:8] = 8'd2;
        req_awsize[5:3] = 3'd3; req_awburst[3:2] = BURST_WRAP; req_wvalid = 2'b10;
        #1;
        total_cnt++;
        if (req_awready !== 2'b10)
            $display("FAIL stall_pick got=%b exp=10", req_awready);
        else pass_cnt++;
        @(negedge clk);
        req_awvalid = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #1;
            total_cnt++;
            if ({axi_awvalid, axi_awaddr, axi_awlen, axi_awburst, req_wready} !== {1'b1, 32'hDEAD_0000, 8'd2, BURST_WRAP, 2'b00})
                $display("FAIL stall_aw%0d got=%h exp=%h", c, {axi_awvalid, axi_awaddr, axi_awlen, axi_awburst, req_wready},
                         {1'b1, 32'hDEAD_0000, 8'd2, BURST_WRAP, 2'b00});
            else pass_cnt++;
            @(negedge clk);
        end
        axi_awready = 1'b1;
        @(negedge clk);
        axi_awready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            axi_wready = (c % 2 == 0);
            req_wdata[127:64] = 64'h1111_0000_0000_0000 + 64'(c);
            #1;
            total_cnt++;
            if ({axi_wvalid, axi_wlast, axi_wdata} !== {1'b1, exp_last[c], 64'h1111_0000_0000_0000 + 64'(c)})
                $display("FAIL stall_w%0d got=%h exp=%h", c, {axi_wvalid, axi_wlast, axi_wdata},
                         {1'b1, exp_last[c], 64'h1111_0000_0000_0000 + 64'(c)});
            else pass_cnt++;
            @(negedge clk);
        end
        req_wvalid = 2'b00; axi_wready = 1'b0;
        #1;
        total_cnt++;
        if ({busy, req_bvalid, axi_wvalid, axi_awaddr} !== {1'b1, 2'b00, 1'b0, 32'hDEAD_0000})
            $display("FAIL stall_resp got=%h exp=%h", {busy, req_bvalid, axi_wvalid, axi_awaddr},
                     {1'b1, 2'b00, 1'b0, 32'hDEAD_0000});
        else pass_cnt++;
        axi_bvalid = 1'b1; req_bready = 2'b10;
        #1;
        total_cnt++;
        if ({req_bvalid, axi_bready} !== 3'b101)
            $display("FAIL stall_b got=%b exp=101", {req_bvalid, axi_bready});
        else pass_cnt++;
        @(negedge clk);
        axi_bvalid = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL stall_done got=%b exp=0", busy);
        else pass_cnt++;
    endtask

    task test_slverr();
        clear_inputs();
        @(negedge clk);
        req_awvalid = 2'b01; req_awaddr[31:0] = 32'h0000_4000; req_awlen[7:0] = 8'd0;
        req_wvalid = 2'b01; axi_awready = 1'b1;
        axi_bvalid = 1'b1; axi_bresp = RESP_SLVERR; req_bready = 2'b01;
        #1;
        total_cnt++;
        if (req_awready !== 2'b01)
            $display("FAIL err_pick got=%b exp=01", req_awready);
        else pass_cnt++;
        @(negedge clk);
        req_awvalid = 2'b00;
        @(negedge clk); #1;
        total_cnt++;
        if ({axi_bready, req_bvalid, axi_wvalid} !== 4'b0001)
            $display("FAIL early_b got=%b exp=0001", {axi_bready, req_bvalid, axi_wvalid});
        else pass_cnt++;
        axi_wready = 1'b1;
        @(negedge clk);
        req_bready = 2'b00; req_wvalid = 2'b00;
        for (int c = 0; c < 2; c++) begin
            #1;
            total_cnt++;
            if ({axi_bready, req_bvalid, req_bresp, busy} !== {1'b0, 2'b01, 4'b0010, 1'b1})
                $display("FAIL err_hold%0d got=%b exp=%b", c, {axi_bready, req_bvalid, req_bresp, busy},
                         {1'b0, 2'b01, 4'b0010, 1'b1});
            else pass_cnt++;
            @(negedge clk);
        end
        req_bready = 2'b01;
        #1;
        total_cnt++;
        if ({axi_bready, req_bresp} !== 5'b1_0010)
            $display("FAIL err_ready got=%b exp=10010", {axi_bready, req_bresp});
        else pass_cnt++;
        @(negedge clk);
        axi_bvalid = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL err_done got=%b exp=0", busy);
        else pass_cnt++;
    endtask

    task test_reset_mid();
        clear_inputs();
        @(negedge clk);
        req_awvalid = 2'b10; req_awaddr[63:32] = 32'h0000_5000; req_awlen[15:8] = 8'd3;
        req_wvalid = 2'b10; axi_awready = 1'b1; axi_wready = 1'b1;
        #1;
        total_cnt++;
        if (req_awready !== 2'b10)
            $display("FAIL mid_pick got=%b exp=10", req_awready);
        else pass_cnt++;
        @(negedge clk);
        req_awvalid = 2'b00;
        @(negedge clk); #1;
        total_cnt++;
        if ({axi_wvalid, axi_wlast, req_wready} !== 4'b1010)
            $display("FAIL mid_beat1 got=%b exp=1010", {axi_wvalid, axi_wlast, req_wready});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, grant, axi_wvalid, req_wready, axi_awvalid, axi_wlast, axi_awaddr} !== '0)
            $display("FAIL mid_reset got=%h exp=0", {busy, grant, axi_wvalid, req_wready, axi_awvalid, axi_wlast, axi_awaddr});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; req_wvalid = 2'b00; req_awvalid = 2'b11;
        #1;
        total_cnt++;
        if (req_awready !== 2'b01)
            $display("FAIL mid_regrant got=%b exp=01", req_awready);
        else pass_cnt++;
        @(negedge clk);
        req_awvalid = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_two_req();
        test_awlen0_early_w();
        test_stall();
        test_slverr();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Shares one AXI write master channel (AW, W, B) between NREQ independent write requesters.
- Each requester presents a complete burst: address beat, data beats, response.
- The arbiter grants one requester at a time in round-robin order and holds the grant until that burst's B handshake completes.
- It registers the AW beat, muxes W and B to and from the granted requester, and generates axi_wlast from a beat counter.
- It sits between the write-channel source instances and the single fsm/ila-facing AXI write port.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 64, write data width (DW/8 strobe bits).

Ports:
- clk  in  1  global clock
- rst  in  1  global reset, asynchronous, active-high
- req_awvalid  in  NREQ  per-requester burst request
- req_awready  out  NREQ  one-cycle pulse: AW fields captured
- req_awaddr  in  NREQ*AW  packed, requester i at [i*AW +: AW]
- req_awlen  in  NREQ*8  beats-1
- req_awsize  in  NREQ*3  burst size
- req_awburst  in  NREQ*2  burst type
- req_wdata  in  NREQ*DW  packed write data
- req_wstrb  in  NREQ*DW/8  packed strobes
- req_wvalid  in  NREQ  data valid
- req_wready  out  NREQ  data ready, granted requester only
- req_bresp  out  NREQ*2  response, valid only for granted index
- req_bvalid  out  NREQ  response valid, granted requester only
- req_bready  in  NREQ  response ready
- axi_awaddr / axi_awlen / axi_awsize / axi_awburst  out  AW/8/3/2  registered AW beat
- axi_awvalid  out  1
- axi_awready  in  1
- axi_wdata  out  DW
- axi_wstrb  out  DW/8
- axi_wlast  out  1
- axi_wvalid  out  1
- axi_wready  in  1
- axi_bresp  in  2
- axi_bvalid  in  1
- axi_bready  out  1
- grant  out  NREQ  one-hot owner; 0 in IDLE
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all outputs 0.
  - rr_ptr=NREQ-1, so requester 0 wins first.
  - beat_cnt=0.
- IDLE:
  - If any req_awvalid, pick the first set bit searching from rr_ptr+1 (mod NREQ) upward.
  - Latch index g; capture that requester's AW fields into the axi_aw* registers.
  - Pulse req_awready[g]=1 for this single cycle; go to ADDR.
  - No request: stay in IDLE.
- ADDR:
  - axi_awvalid=1 (registered; first asserted the cycle after the grant, so latency is 1 cycle).
  - AW fields held stable.
  - On axi_awvalid&axi_awready: awvalid→0, beat_cnt←awlen, go to DATA.
- DATA (combinational mux through g):
  - axi_wvalid=req_wvalid[g], axi_wdata/axi_wstrb from slice g.
  - req_wready[g]=axi_wready; all other req_wready=0.
  - axi_wlast=(beat_cnt==0).
  - On a W handshake with beat_cnt!=0: beat_cnt−1.
  - On a W handshake with axi_wlast: go to RESP.
  - awlen=0 yields a single beat with wlast high.
  - beat_cnt is 8 bits, covering 1..256 beats; it never wraps below 0.
- RESP:
  - req_bvalid[g]=axi_bvalid; req_bresp slice g=axi_bresp, passed unchanged (SLVERR/DECERR included).
  - axi_bready=req_bready[g].
  - On B handshake: rr_ptr←g, go to IDLE. The next grant may occur in the following cycle.
- Write data is never accepted outside DATA: all req_wready=0, axi_wvalid=0.
  - A requester asserting wvalid early simply waits.
- Requests arriving while busy are held off, with no req_awready.
  - Requesters must keep awvalid and fields stable until req_awready.
- Fairness: a requester that is continuously requesting is granted within NREQ-1 other bursts.
- Deasserting a req_awvalid at the grant cycle is illegal, since the sample happens in that cycle.
- axi_wvalid, axi_wdata and axi_bready are combinational from requester inputs.
  - req_wready and req_bvalid are combinational from AXI inputs.
  - There is no combinational path from axi_awready to any output except through state.
- A B response arriving before the W beats complete is ignored; axi_bready=0 outside RESP.
- grant=one-hot(g) in ADDR/DATA/RESP.

Decomposition:
- Package axi_arb_pkg:
  - state enum {IDLE, ADDR, DATA, RESP}.
  - AXI burst constants (FIXED=2'b00, INCR=2'b01, WRAP=2'b10).
  - AXI resp constants (OKAY, EXOKAY, SLVERR, DECERR).
- Sub-module rr_arbiter (NREQ):
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and encoded index. Purely combinational.

Test Plan:
- Single requester, req0 awaddr=0x1000, awlen=3, axi_awready=1, wready=1 → axi_awvalid 1 cycle after req_awready pulse; 4 W beats, wlast only on 4th; bresp=OKAY returned on req_bvalid[0]; busy drops the cycle after B handshake.
- req0 and req1 request simultaneously from reset → req0 granted first, req1 granted in the cycle after req0's B handshake; with both re-requesting, grants alternate 0,1,0,1.
- awlen=0, wvalid presented with awvalid → req_wready=0 until DATA; exactly one beat with wlast=1.
- axi_awready held low 5 cycles, then wready toggled 1/0 during 3-beat burst → AW fields stable throughout; beat_cnt decrements only on handshakes; wlast aligned to 3rd accepted beat.
- axi_bresp=SLVERR with req_bready low 2 cycles → axi_bready low, bresp passed unchanged, state stays RESP until req_bready=1.
- rst asserted mid-DATA (beat 2 of 4) → all outputs 0 immediately, state IDLE, next grant goes to req0.
